// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester arbiter for the single mem4k port with in-order read return routing
module mem_arbiter #(
    parameter int AW         = 16,
    parameter int DW         = 16,
    parameter int RD_LATENCY = 1,
    parameter int FIXED_PRIO = 0
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req0_rd,
    input  logic          i_req0_wr,
    input  logic [AW-1:0] i_req0_addr,
    input  logic [DW-1:0] i_req0_wrdata,
    output logic          o_req0_ack,
    output logic [DW-1:0] o_req0_rddata,
    output logic          o_req0_rdvalid,
    input  logic          i_req1_rd,
    input  logic          i_req1_wr,
    input  logic [AW-1:0] i_req1_addr,
    input  logic [DW-1:0] i_req1_wrdata,
    output logic          o_req1_ack,
    output logic [DW-1:0] o_req1_rddata,
    output logic          o_req1_rdvalid,
    output logic [AW-1:0] o_mem_addr,
    output logic          o_mem_rd,
    output logic          o_mem_wr,
    output logic [DW-1:0] o_mem_wrdata,
    input  logic [DW-1:0] i_mem_rddata
);
    logic                  act0, act1, gnt0, gnt1, rv0, rv1;
    logic                  last_grant, mem_owner;
    logic [RD_LATENCY-1:0] tag_v, tag_o;
    logic [DW-1:0]         rddata0_q, rddata1_q;

    // grant selection (ties go to the requester that did not win last) and read-return decode
    always_comb begin
        act0 = i_req0_rd | i_req0_wr;
        act1 = i_req1_rd | i_req1_wr;
        gnt0 = act0 & (!act1 || FIXED_PRIO != 0 || last_grant);
        gnt1 = act1 & !gnt0;
        rv0  = tag_v[RD_LATENCY-1] & !tag_o[RD_LATENCY-1];
        rv1  = tag_v[RD_LATENCY-1] & tag_o[RD_LATENCY-1];
    end

    assign o_req0_ack     = gnt0;
    assign o_req1_ack     = gnt1;
    assign o_req0_rdvalid = rv0;
    assign o_req1_rdvalid = rv1;
    assign o_req0_rddata  = rv0 ? i_mem_rddata : rddata0_q;
    assign o_req1_rddata  = rv1 ? i_mem_rddata : rddata1_q;

    // register the granted command onto the memory port; write wins over read
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_mem_rd     <= 1'b0;
            o_mem_wr     <= 1'b0;
            o_mem_addr   <= '0;
            o_mem_wrdata <= '0;
            mem_owner    <= 1'b0;
            last_grant   <= 1'b1;
        end else begin
            o_mem_rd <= gnt0 ? i_req0_rd & !i_req0_wr : gnt1 & i_req1_rd & !i_req1_wr;
            o_mem_wr <= gnt0 ? i_req0_wr : gnt1 & i_req1_wr;
            if (gnt0 | gnt1) begin
                o_mem_addr   <= gnt0 ? i_req0_addr : i_req1_addr;
                o_mem_wrdata <= gnt0 ? i_req0_wrdata : i_req1_wrdata;
                mem_owner    <= gnt1;
                last_grant   <= gnt1;
            end
        end
    end

    // owner tags follow each issued read until its data arrives; returned data is held per requester
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tag_v     <= '0;
            tag_o     <= '0;
            rddata0_q <= '0;
            rddata1_q <= '0;
        end else begin
            tag_v[0] <= o_mem_rd;
            tag_o[0] <= mem_owner;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_o[i] <= tag_o[i-1];
            end
            if (rv0) rddata0_q <= i_mem_rddata;
            if (rv1) rddata1_q <= i_mem_rddata;
        end
    end
endmodule
